// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state type and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam int MDU_ITER    = 32;
  localparam int MDU_LATENCY = MDU_ITER + 1;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq_core.sv
// Unsigned iterative datapath: shift-add multiply and restoring divide over a
// 2*XLEN accumulator; one iteration per asserted step.
module mdu_seq_core import mdu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] acc_s;
  logic [XLEN-1:0]   b_r;
  logic [XLEN:0]     add_s;
  logic [XLEN:0]     sub_s;

  // Next accumulator value for one multiply or divide iteration
  always_comb begin
    add_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, b_r};
    // partial remainder after the left shift is 33 bits; MSB of the difference is the borrow
    sub_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, b_r};
    if (is_div) begin
      if (!sub_s[XLEN]) begin
        acc_s = {sub_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_s = {acc_r[2*XLEN-2:0], 1'b0};
      end
    end else if (acc_r[0]) begin
      acc_s = {add_s, acc_r[XLEN-1:1]};
    end else begin
      acc_s = {1'b0, acc_r[2*XLEN-1:1]};
    end
  end

  // Accumulator and divisor/multiplicand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {(2*XLEN){1'b0}};
      b_r   <= {XLEN{1'b0}};
    end else if (load) begin
      acc_r <= {{XLEN{1'b0}}, a};
      b_r   <= b;
    end else if (step) begin
      acc_r <= acc_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign prod = acc_r;
  assign quot = acc_r[XLEN-1:0];
  assign rem  = acc_r[2*XLEN-1:XLEN];

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers: FSM, sign handling and write-back.
// Optional macro MDU_CANCEL_EN adds a cancel input that aborts CALC/FIX.
module mdu_hilo import mdu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
`ifdef MDU_CANCEL_EN
  input  logic            cancel,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  mdu_state_e        state_r, state_s;
  logic [CW-1:0]     count_r;
  logic              is_div_r, neg_q_r, neg_r_r, div0_r;
  logic [XLEN-1:0]   a_orig_r;
  logic              accept_s, mt_hi_s, mt_lo_s, cancel_s;
  logic              a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [XLEN-1:0]   hi_s, lo_s;
  logic              done_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  assign accept_s = start && (state_r == ST_IDLE) && !op[2];
  assign mt_hi_s  = start && (state_r == ST_IDLE) && (op == MDU_MTHI);
  assign mt_lo_s  = start && (state_r == ST_IDLE) && (op == MDU_MTLO);
  // op[0] clear selects the signed variants
  assign a_neg_s  = !op[0] && A[XLEN-1];
  assign b_neg_s  = !op[0] && B[XLEN-1];
  assign a_mag_s  = a_neg_s ? -A : A;
  assign b_mag_s  = b_neg_s ? -B : B;

  mdu_seq_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_s),
    .step   (state_r == ST_CALC),
    .is_div (is_div_r),
    .a      (a_mag_s),
    .b      (b_mag_s),
    .prod   (prod_s),
    .quot   (quot_s),
    .rem    (rem_s)
  );

  // State register and per-operation latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      count_r  <= {CW{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      a_orig_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        count_r  <= {CW{1'b0}};
        is_div_r <= op[1];
        neg_q_r  <= a_neg_s ^ b_neg_s;
        neg_r_r  <= a_neg_s;
        div0_r   <= (B == {XLEN{1'b0}});
        a_orig_r <= A;
      end else if (state_r == ST_CALC) begin
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = accept_s ? ST_CALC : ST_IDLE;
      ST_CALC: begin
        if (cancel_s) begin
          state_s = ST_IDLE;
        end else if (count_r == LAST_CNT) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output logic: next HI/LO/done values
  always_comb begin
    hi_s   = hi;
    lo_s   = lo;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mt_hi_s) begin
          hi_s = A;
        end else if (mt_lo_s) begin
          lo_s = A;
        end else begin
          hi_s = hi;
        end
      end
      ST_FIX: begin
        // cancel wins over write-back
        if (cancel_s) begin
          done_s = 1'b0;
        end else begin
          done_s = 1'b1;
          if (!is_div_r) begin
            {hi_s, lo_s} = neg_q_r ? -prod_s : prod_s;
          end else if (div0_r) begin
            hi_s = a_orig_r;
            lo_s = DIV0_LO;
          end else begin
            hi_s = neg_r_r ? -rem_s : rem_s;
            lo_s = neg_q_r ? -quot_s : quot_s;
          end
        end
      end
      default: done_s = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= {XLEN{1'b0}};
      lo   <= {XLEN{1'b0}};
    end else begin
      busy <= (state_s != ST_IDLE);
      done <= done_s;
      hi   <= hi_s;
      lo   <= lo_s;
    end
  end

endmodule
